// File: rtl/recovery_controller.sv
// PC-rollback recovery sequencer: checkpoints clean commits, issues the restore pulse,
// stalls through the flush and escalates to a sticky fatal state after repeated failed retries.
// Optional MONITOR watchdog is enabled by defining RECOVERY_WATCHDOG_EN.
module recovery_controller #(
    parameter int          MAX_RETRY    = 3,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
`ifdef RECOVERY_WATCHDOG_EN
    ,
    parameter int          WDT_CYCLES   = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fault_detect,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    output logic [31:0] pc_saved,
    output logic        recovery_en,
    output logic        stall,
    output logic [3:0]  retry_cnt,
    output logic        recovery_done,
    output logic        fatal_error
);

    typedef enum logic [2:0] {
        IDLE,
        RESTORE,
        FLUSH,
        MONITOR,
        FATAL
    } state_t;

    state_t      state_reg;
    logic [3:0]  flush_cnt_reg;
    logic        wdt_expire;
    logic        take_fault;
    logic        retry_exhausted;

`ifdef RECOVERY_WATCHDOG_EN
    logic [7:0]  wdt_cnt_reg;

    // A clean commit in the same cycle as expiry wins, so expiry only counts without a commit.
    assign wdt_expire = (wdt_cnt_reg == 8'(WDT_CYCLES - 1)) && !commit_valid;
`else
    assign wdt_expire = 1'b0;
`endif

    assign take_fault = ((state_reg == IDLE) && fault_detect) ||
                        ((state_reg == MONITOR) && (fault_detect || wdt_expire));
    assign retry_exhausted = (retry_cnt == 4'(MAX_RETRY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            flush_cnt_reg <= 4'd0;
            pc_saved      <= RESET_PC;
            recovery_en   <= 1'b0;
            stall         <= 1'b0;
            retry_cnt     <= 4'd0;
            recovery_done <= 1'b0;
            fatal_error   <= 1'b0;
`ifdef RECOVERY_WATCHDOG_EN
            wdt_cnt_reg   <= 8'd0;
`endif
        end else begin
            recovery_en   <= 1'b0;
            recovery_done <= 1'b0;

            if (take_fault) begin
                // Faulting instruction never updates the checkpoint, even if it also commits.
                stall <= 1'b1;
                if (retry_exhausted) begin
                    state_reg   <= FATAL;
                    fatal_error <= 1'b1;
                end else begin
                    state_reg   <= RESTORE;
                    retry_cnt   <= retry_cnt + 4'd1;
                    recovery_en <= 1'b1;
                end
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (commit_valid) begin
                            pc_saved <= commit_pc;
                        end
                    end
                    RESTORE: begin
                        flush_cnt_reg <= 4'(FLUSH_CYCLES - 1);
                        stall         <= 1'b1;
                        state_reg     <= FLUSH;
                    end
                    FLUSH: begin
                        if (flush_cnt_reg == 4'd0) begin
                            stall     <= 1'b0;
                            state_reg <= MONITOR;
`ifdef RECOVERY_WATCHDOG_EN
                            wdt_cnt_reg <= 8'd0;
`endif
                        end else begin
                            flush_cnt_reg <= flush_cnt_reg - 4'd1;
                        end
                    end
                    MONITOR: begin
                        if (commit_valid) begin
                            pc_saved      <= commit_pc;
                            retry_cnt     <= 4'd0;
                            recovery_done <= 1'b1;
                            state_reg     <= IDLE;
                        end
`ifdef RECOVERY_WATCHDOG_EN
                        else begin
                            wdt_cnt_reg <= wdt_cnt_reg + 8'd1;
                        end
`endif
                    end
                    FATAL: begin
                        stall       <= 1'b1;
                        fatal_error <= 1'b1;
                    end
                    default: begin
                        state_reg <= IDLE;
                        stall     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
